// File: rtl/tail_light_sequencer.sv
// rtl/tail_light_sequencer.sv - three-lamp turn/hazard/brake tail-light sequencer
module tail_light_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic active
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    lamps_q, lamps_d;
    logic          active_q, active_d;
    logic          tick;
    logic          hz, lt, rt;

    assign tick = (cnt_q == CNT_MAX);
    assign hz   = hazard | (left & right);
    assign lt   = left & ~hz;
    assign rt   = right & ~hz;

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:    state_d = hz ? HAZ : lt ? L1 : rt ? R1 : IDLE;
                L1:      state_d = hz ? HAZ : lt ? L2 : IDLE;
                L2:      state_d = hz ? HAZ : lt ? L3 : IDLE;
                R1:      state_d = hz ? HAZ : rt ? R2 : IDLE;
                R2:      state_d = hz ? HAZ : rt ? R3 : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Lamp order {la, lb, lc, ra, rb, rc}; outputs follow the next state so they
    // change on the same edge as the state register.
    always_comb begin
        lamps_d  = 6'b000000;
        active_d = (state_d != IDLE);
        case (state_d)
            IDLE:    lamps_d = brake ? 6'b111111 : 6'b000000;
            L1:      lamps_d = {3'b100, {3{brake}}};
            L2:      lamps_d = {3'b110, {3{brake}}};
            L3:      lamps_d = {3'b111, {3{brake}}};
            R1:      lamps_d = {{3{brake}}, 3'b100};
            R2:      lamps_d = {{3{brake}}, 3'b110};
            R3:      lamps_d = {{3{brake}}, 3'b111};
            default: lamps_d = 6'b111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lamps_q  <= 6'b000000;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lamps_q  <= lamps_d;
            active_q <= active_d;
        end
    end

    assign {la, lb, lc, ra, rb, rc} = lamps_q;
    assign active = active_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb/tb_tail_light_sequencer.sv - directed self-checking bench for tail_light_sequencer
module tb_tail_light_sequencer;

    logic clk;
    logic reset;
    logic left, right, hazard, brake;
    logic la, lb, lc, ra, rb, rc, active;
    logic [5:0] lamps;
    int pass_cnt;
    int total_cnt;

    assign lamps = {la, lb, lc, ra, rb, rc};

    tail_light_sequencer #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .la     (la),
        .lb     (lb),
        .lc     (lc),
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        left = 0; right = 0; hazard = 0; brake = 0;
        reset = 1;
        step(2);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (lamps !== 6'b000000) $display("FAIL reset_lamps got=%b exp=%b", lamps, 6'b000000);
        else pass_cnt++;
        total_cnt++;
        if (active !== 1'b0) $display("FAIL reset_active got=%b exp=0", active);
        else pass_cnt++;
    endtask

    task automatic test_left_sequence();
        do_reset();
        left = 1;
        step(3);
        total_cnt++;
        if (lamps !== 6'b000000) $display("FAIL left_e3 got=%b exp=%b", lamps, 6'b000000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({lamps, active} !== 7'b100000_1) $display("FAIL left_e4 got=%b exp=%b", {lamps, active}, 7'b100000_1);
        else pass_cnt++;
        step(4);
        total_cnt++;
        if (lamps !== 6'b110000) $display("FAIL left_e8 got=%b exp=%b", lamps, 6'b110000);
        else pass_cnt++;
        step(4);
        total_cnt++;
        if (lamps !== 6'b111000) $display("FAIL left_e12 got=%b exp=%b", lamps, 6'b111000);
        else pass_cnt++;
        step(4);
        total_cnt++;
        if ({lamps, active} !== 7'b000000_0) $display("FAIL left_e16 got=%b exp=%b", {lamps, active}, 7'b000000_0);
        else pass_cnt++;
        step(4);
        total_cnt++;
        if (lamps !== 6'b100000) $display("FAIL left_e20 got=%b exp=%b", lamps, 6'b100000);
        else pass_cnt++;
    endtask

    task automatic test_release();
        do_reset();
        left = 1;
        step(8);
        total_cnt++;
        if (lamps !== 6'b110000) $display("FAIL rel_e8 got=%b exp=%b", lamps, 6'b110000);
        else pass_cnt++;
        step(1);
        left = 0;
        step(2);
        total_cnt++;
        if (lamps !== 6'b110000) $display("FAIL rel_e11 got=%b exp=%b", lamps, 6'b110000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({lamps, active} !== 7'b000000_0) $display("FAIL rel_e12 got=%b exp=%b", {lamps, active}, 7'b000000_0);
        else pass_cnt++;
        step(4);
        total_cnt++;
        if (lamps !== 6'b000000) $display("FAIL rel_e16 got=%b exp=%b", lamps, 6'b000000);
        else pass_cnt++;
    endtask

    task automatic test_hazard(input logic use_lr);
        logic [5:0] exp_seq [3];
        exp_seq[0] = 6'b111111;
        exp_seq[1] = 6'b000000;
        exp_seq[2] = 6'b111111;
        do_reset();
        if (use_lr) begin
            left = 1; right = 1;
        end else begin
            hazard = 1;
        end
        for (int i = 0; i < 3; i++) begin
            step(4);
            total_cnt++;
            if (lamps !== exp_seq[i])
                $display("FAIL hazard_lr%0d_step%0d got=%b exp=%b", use_lr, i, lamps, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_brake();
        do_reset();
        brake = 1;
        step(1);
        total_cnt++;
        if ({lamps, active} !== 7'b111111_0) $display("FAIL brake_idle got=%b exp=%b", {lamps, active}, 7'b111111_0);
        else pass_cnt++;
        brake = 0;
        step(1);
        total_cnt++;
        if (lamps !== 6'b000000) $display("FAIL brake_release got=%b exp=%b", lamps, 6'b000000);
        else pass_cnt++;
        do_reset();
        left = 1;
        step(8);
        brake = 1;
        step(1);
        total_cnt++;
        if (lamps !== 6'b110111) $display("FAIL brake_l2 got=%b exp=%b", lamps, 6'b110111);
        else pass_cnt++;
        do_reset();
        right = 1;
        step(4);
        brake = 1;
        step(1);
        total_cnt++;
        if (lamps !== 6'b111100) $display("FAIL brake_r1 got=%b exp=%b", lamps, 6'b111100);
        else pass_cnt++;
        do_reset();
        hazard = 1;
        step(4);
        brake = 1;
        step(1);
        total_cnt++;
        if ({lamps, active} !== 7'b111111_1) $display("FAIL brake_haz got=%b exp=%b", {lamps, active}, 7'b111111_1);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if ({lamps, active} !== 7'b111111_0) $display("FAIL brake_haz_off got=%b exp=%b", {lamps, active}, 7'b111111_0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        right = 1;
        step(12);
        total_cnt++;
        if (lamps !== 6'b000111) $display("FAIL mid_r3 got=%b exp=%b", lamps, 6'b000111);
        else pass_cnt++;
        reset = 1;
        step(1);
        reset = 0;
        total_cnt++;
        if ({lamps, active} !== 7'b000000_0) $display("FAIL mid_reset got=%b exp=%b", {lamps, active}, 7'b000000_0);
        else pass_cnt++;
        step(3);
        total_cnt++;
        if (lamps !== 6'b000000) $display("FAIL mid_e3 got=%b exp=%b", lamps, 6'b000000);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({lamps, active} !== 7'b000100_1) $display("FAIL mid_e4 got=%b exp=%b", {lamps, active}, 7'b000100_1);
        else pass_cnt++;
    endtask

    task automatic test_preempt();
        do_reset();
        right = 1;
        step(8);
        total_cnt++;
        if (lamps !== 6'b000110) $display("FAIL pre_r2 got=%b exp=%b", lamps, 6'b000110);
        else pass_cnt++;
        hazard = 1;
        step(3);
        total_cnt++;
        if (lamps !== 6'b000110) $display("FAIL pre_e11 got=%b exp=%b", lamps, 6'b000110);
        else pass_cnt++;
        step(1);
        total_cnt++;
        if ({lamps, active} !== 7'b111111_1) $display("FAIL pre_e12 got=%b exp=%b", {lamps, active}, 7'b111111_1);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1; left = 0; right = 0; hazard = 0; brake = 0;
        test_reset();
        test_left_sequence();
        test_release();
        test_hazard(1'b1);
        test_hazard(1'b0);
        test_brake();
        test_reset_mid();
        test_preempt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
